// File: rtl/tile_out_stream_merge_pkg.sv
// Shared types and constants for the four-lane outbound stream merger.
package tile_stream_pkg;

  localparam int NUM_LANES    = 4;
  localparam int DEF_BW       = 32;
  localparam int DEF_SEQ_W    = 8;

  // Header layout: lane index sits directly above the sequence field.
  localparam int HDR_LANE_LSB = DEF_SEQ_W;
  localparam int HDR_LANE_W   = 2;

  // The header flit is emitted on the IDLE->DATA edge, so it needs no state.
  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_e;

endpackage

// File: rtl/tile_out_stream_merge_if.sv
// Bundles the four upstream lanes, the merged downstream link and status.
interface tile_out_stream_merge_if #(
  parameter int BW  = 32,
  parameter int BWB = BW / 8
);

  logic [3:0]       s_TVALID;
  logic [4*BW-1:0]  s_TDATA;
  logic [4*BWB-1:0] s_TKEEP;
  logic [3:0]       s_TLAST;
  logic [3:0]       s_TREADY;

  logic             m_TVALID;
  logic [BW-1:0]    m_TDATA;
  logic [BWB-1:0]   m_TKEEP;
  logic             m_TLAST;
  logic             m_TREADY;

  logic [1:0]       grant_lane;
  logic             busy;

  // Environment side: drives the lanes and downstream ready.
  modport master (
    output s_TVALID, s_TDATA, s_TKEEP, s_TLAST, m_TREADY,
    input  s_TREADY, m_TVALID, m_TDATA, m_TKEEP, m_TLAST, grant_lane, busy
  );

  // Merger side.
  modport slave (
    input  s_TVALID, s_TDATA, s_TKEEP, s_TLAST, m_TREADY,
    output s_TREADY, m_TVALID, m_TDATA, m_TKEEP, m_TLAST, grant_lane, busy
  );

endinterface

// File: rtl/tile_rr_arb4.sv
// Combinational 4-way round-robin picker: first request at or above ptr.
module tile_rr_arb4
  import tile_stream_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] gnt_idx_o,
  output logic       any_req_o
);

  logic [1:0] idx;

  // Scan downward in distance from ptr so the nearest request wins last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    gnt_idx_o = ptr_i;
    any_req_o = |req_i;
    idx       = ptr_i;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = ptr_i + 2'(k);
      if (req_i[idx]) gnt_idx_o = idx;
    end
  end

endmodule

// File: rtl/tile_out_stream_merge.sv
// Packet-atomic round-robin merge of four lanes with a lane/sequence header.
module tile_out_stream_merge
  import tile_stream_pkg::*;
#(
  parameter int BW    = DEF_BW,
  parameter int SEQ_W = DEF_SEQ_W
) (
  input logic                    clk_line,
  input logic                    clk_line_rst_high,
  tile_out_stream_merge_if.slave bus
);

  localparam int BWB = BW / 8;

  state_e           state_q, state_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [SEQ_W-1:0] seq_q [NUM_LANES];
  logic [SEQ_W-1:0] seq_d [NUM_LANES];
  logic             m_valid_q, m_valid_d;
  logic [BW-1:0]    m_data_q, m_data_d;
  logic [BWB-1:0]   m_keep_q, m_keep_d;
  logic             m_last_q, m_last_d;

  logic [3:0]       s_ready;
  logic             can_load;
  logic [1:0]       arb_idx;
  logic             arb_any;
  logic [BW-1:0]    g_data;
  logic [BWB-1:0]   g_keep;

  assign can_load = !m_valid_q || bus.m_TREADY;
  assign g_data   = bus.s_TDATA[int'(gnt_q)*BW +: BW];
  assign g_keep   = bus.s_TKEEP[int'(gnt_q)*BWB +: BWB];

  tile_rr_arb4 u_arb (
    .req_i     (bus.s_TVALID),
    .ptr_i     (rr_q),
    .gnt_idx_o (arb_idx),
    .any_req_o (arb_any)
  );

  // Next-state: arbitrate and emit header in IDLE, forward granted lane in DATA.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    seq_d     = seq_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    s_ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (can_load) begin
          m_valid_d = 1'b0;
          if (arb_any) begin
            gnt_d                           = arb_idx;
            m_valid_d                       = 1'b1;
            m_data_d                        = '0;
            m_data_d[SEQ_W +: HDR_LANE_W]   = arb_idx;
            m_data_d[SEQ_W-1:0]             = seq_q[arb_idx];
            m_keep_d                        = '1;
            m_last_d                        = 1'b0;
            state_d                         = DATA;
          end
        end
      end
      DATA: begin
        if (can_load) begin
          s_ready[gnt_q] = 1'b1;
          m_valid_d      = bus.s_TVALID[gnt_q];
          if (bus.s_TVALID[gnt_q]) begin
            m_data_d = g_data;
            m_keep_d = g_keep;
            m_last_d = bus.s_TLAST[gnt_q];
            if (bus.s_TLAST[gnt_q]) begin
              seq_d[gnt_q] = seq_q[gnt_q] + 1'b1;
              rr_d         = gnt_q + 2'd1;
              state_d      = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, sequence counters and output register.
  always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
    if (clk_line_rst_high) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      gnt_q     <= '0;
      // NOTE: the sequence counters are architectural state seen by the host, so this small array is reset like any register.
      for (int i = 0; i < NUM_LANES; i++) seq_q[i] <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      seq_q     <= seq_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

  assign bus.s_TREADY   = s_ready;
  assign bus.m_TVALID   = m_valid_q;
  assign bus.m_TDATA    = m_data_q;
  assign bus.m_TKEEP    = m_keep_q;
  assign bus.m_TLAST    = m_last_q;
  assign bus.grant_lane = gnt_q;
  assign bus.busy       = (state_q == DATA);

endmodule

// File: tb/tb_tile_out_stream_merge.sv
// Scoreboard bench for the four-lane stream merger.
module tb_tile_out_stream_merge;
  import tile_stream_pkg::*;

  localparam int BW    = 32;
  localparam int BWB   = 4;
  localparam int SEQ_W = 8;

  typedef struct packed {
    logic [BW-1:0]  data;
    logic [BWB-1:0] keep;
    logic           last;
  } beat_t;

  logic clk_line = 1'b0;
  logic clk_line_rst_high = 1'b1;
  always #5 clk_line = ~clk_line;

  tile_out_stream_merge_if #(.BW(BW)) bus ();

  tile_out_stream_merge #(.BW(BW), .SEQ_W(SEQ_W)) dut (
    .clk_line          (clk_line),
    .clk_line_rst_high (clk_line_rst_high),
    .bus               (bus)
  );

  beat_t tx_q  [4][$];   // beats still to be offered per lane
  beat_t exp_q [4][$];   // expected output stream per lane (header + beats)
  int    seq_m [4];
  bit    mid   [4];
  int    hdr_log [$];
  bit    rdy_pat [$];
  bit    gap_en  = 1'b0;
  bit    rdy_rand = 1'b0;
  int    cur_lane = -1;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue one packet on a lane and record the merged output it must produce.
  task automatic send_pkt(input int l, input int len, input logic [BW-1:0] base, input bit rnd);
    beat_t b;
    b.data = BW'(l * (1 << HDR_LANE_LSB) + seq_m[l]);
    b.keep = '1;
    b.last = 1'b0;
    exp_q[l].push_back(b);
    seq_m[l] = (seq_m[l] + 1) % (1 << SEQ_W);
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? BW'($urandom) : base + BW'(i);
      b.keep = rnd ? BWB'($urandom_range(15)) : '1;
      b.last = (i == len - 1);
      tx_q[l].push_back(b);
      exp_q[l].push_back(b);
    end
  endtask

  function automatic bit pending();
    bit p = (cur_lane >= 0) || bus.busy || bus.m_TVALID;
    for (int l = 0; l < 4; l++) p |= (tx_q[l].size() != 0) || (exp_q[l].size() != 0);
    return p;
  endfunction

  task automatic wait_idle(input int budget);
    int cyc = 0;
    while (pending() && cyc < budget) begin
      @(negedge clk_line); #3;
      cyc++;
    end
    check("drain_within_budget", cyc < budget, 1);
  endtask

  task automatic check_order(input int first);
    check("hdr_count", hdr_log.size(), 4);
    if (hdr_log.size() == 4)
      for (int k = 0; k < 4; k++) check("rr_order", hdr_log[k], (first + k) % 4);
  endtask

  task automatic do_reset();
    @(negedge clk_line);
    clk_line_rst_high = 1'b1;
    for (int l = 0; l < 4; l++) begin
      tx_q[l].delete();
      exp_q[l].delete();
      seq_m[l] = 0;
      mid[l]   = 1'b0;
    end
    rdy_pat.delete();
    #1;
    check("rst_m_tvalid", bus.m_TVALID, 0);
    check("rst_s_tready", bus.s_TREADY, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_grant", bus.grant_lane, 0);
    check("rst_m_tdata", bus.m_TDATA, 0);
    check("rst_m_tlast", {bus.m_TKEEP, bus.m_TLAST}, 0);
    repeat (2) @(negedge clk_line);
    clk_line_rst_high = 1'b0;
  endtask

  // Driver: presents lane beats and downstream ready, retires accepted beats.
  initial begin
    logic [3:0] acc;
    bus.s_TVALID = '0;
    bus.s_TDATA  = '0;
    bus.s_TKEEP  = '0;
    bus.s_TLAST  = '0;
    bus.m_TREADY = 1'b0;
    forever begin
      @(negedge clk_line);
      if (rdy_pat.size() > 0) bus.m_TREADY = rdy_pat.pop_front();
      else if (rdy_rand)      bus.m_TREADY = ($urandom_range(3) != 0);
      else                    bus.m_TREADY = 1'b1;
      for (int l = 0; l < 4; l++) begin
        if (tx_q[l].size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
          bus.s_TVALID[l]              = 1'b1;
          bus.s_TDATA[l*BW +: BW]      = tx_q[l][0].data;
          bus.s_TKEEP[l*BWB +: BWB]    = tx_q[l][0].keep;
          bus.s_TLAST[l]               = tx_q[l][0].last;
        end else begin
          bus.s_TVALID[l]              = 1'b0;
          bus.s_TDATA[l*BW +: BW]      = BW'($urandom);
          bus.s_TKEEP[l*BWB +: BWB]    = '0;
          bus.s_TLAST[l]               = 1'b0;
        end
      end
      #1;
      acc = bus.s_TVALID & bus.s_TREADY;
      if (!clk_line_rst_high) begin
        check("s_tready_onehot", $countones(bus.s_TREADY) <= 1, 1);
        for (int l = 0; l < 4; l++) begin
          if (acc[l] && tx_q[l].size() > 0) begin
            for (int k = 0; k < 4; k++)
              if (k != l && mid[k]) check("no_interleave", l, k);
            mid[l] = !tx_q[l][0].last;
            void'(tx_q[l].pop_front());
          end
        end
      end
    end
  end

  // Monitor: compares each transferred output beat against the scoreboard.
  initial begin
    bit    stall = 1'b0;
    beat_t held, got, e;
    int    lane;
    forever begin
      @(negedge clk_line); #2;
      if (clk_line_rst_high) begin
        cur_lane = -1;
        stall    = 1'b0;
        continue;
      end
      got = '{data: bus.m_TDATA, keep: bus.m_TKEEP, last: bus.m_TLAST};
      if (stall) begin
        check("stall_valid_held", bus.m_TVALID, 1);
        check("stall_beat_stable", got, held);
      end
      if (bus.m_TVALID && bus.m_TREADY) begin
        if (cur_lane < 0) begin
          lane = int'(got.data[HDR_LANE_LSB +: HDR_LANE_W]);
          hdr_log.push_back(lane);
          cur_lane = lane;
        end
        if (exp_q[cur_lane].size() == 0) begin
          check("unexpected_beat", got, 0);
        end else begin
          e = exp_q[cur_lane].pop_front();
          check("out_data", got.data, e.data);
          check("out_keep_last", {got.keep, got.last}, {e.keep, e.last});
        end
        if (got.last) cur_lane = -1;
      end
      stall = bus.m_TVALID && !bus.m_TREADY;
      held  = got;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Lane 2, three fixed beats: header 0x200 then 0xA, 0xB, 0xC.
    hdr_log.delete();
    send_pkt(2, 3, 32'hA, 1'b0);
    wait_idle(200);
    check("t1_grant_lane", bus.grant_lane, 2);
    check("t1_one_header", hdr_log.size(), 1);

    // All lanes at once; pointer sits just past lane 2.
    hdr_log.delete();
    for (int l = 0; l < 4; l++) send_pkt(l, 1, 32'h100 * (l + 1), 1'b0);
    wait_idle(200);
    check_order(3);

    // Lane 1 shows up mid-way through lane 0's packet.
    hdr_log.delete();
    send_pkt(0, 4, 32'h50, 1'b0);
    for (int c = 0; c < 100 && tx_q[0].size() > 2; c++) @(negedge clk_line);
    send_pkt(1, 3, 32'h70, 1'b0);
    wait_idle(200);
    check("t3_hdr_count", hdr_log.size(), 2);
    if (hdr_log.size() == 2) begin
      check("t3_first_lane", hdr_log[0], 0);
      check("t3_second_lane", hdr_log[1], 1);
    end

    // Downstream stall pattern inside a packet.
    send_pkt(2, 6, 32'h0, 1'b1);
    repeat (3) @(negedge clk_line);
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    wait_idle(200);

    // Random traffic with upstream gaps and downstream backpressure.
    gap_en   = 1'b1;
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_pkt($urandom_range(3), $urandom_range(1, 6), 32'h0, 1'b1);
      repeat ($urandom_range(0, 4)) @(negedge clk_line);
    end
    wait_idle(4000);
    gap_en   = 1'b0;
    rdy_rand = 1'b0;

    // Reset in the middle of a lane 1 packet.
    send_pkt(1, 8, 32'h0, 1'b1);
    for (int c = 0; c < 100 && tx_q[1].size() > 5; c++) @(negedge clk_line);
    check("mid_pkt_busy", bus.busy, 1);
    do_reset();
    hdr_log.delete();
    for (int l = 0; l < 4; l++) send_pkt(l, 1, 32'h900 + l, 1'b0);
    wait_idle(200);
    check_order(0);

    // Sequence wrap on lane 3.
    do_reset();
    for (int i = 0; i < 257; i++) send_pkt(3, 1, BW'(i), 1'b0);
    wait_idle(5000);
    check("wrap_seq_model", seq_m[3], 1);

    for (int l = 0; l < 4; l++) check("scoreboard_empty", exp_q[l].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
